aes256_ctr_core_scheduler: RTL
==============================

// Module: aes256_ctr_core_scheduler
// PURPOSE
// - Sequences NUM_AES_CORES AES-256 block cores for CTR mode: issues consecutive counter blocks, retires keystream in order.
// - Sits between the IV/control register file and the plaintext XOR stage.
// - Key expansion is outside this block. Each core slot also acts as a one-entry keystream buffer.
// PARAMETERS
// - NUM_AES_CORES     2   number of core slots (1..8); round-robin issue and retire
// - IV_COUNTER_WIDTH  32  low IV bits that increment; upper 128-W bits are fixed per session
// PORTS
// - clk           in   1      clock
// - rst           in   1      async reset, active-high
// - load          in   1      pulse: start a new session with iv
// - iv            in   128    initial counter block, sampled when load=1
// - enable        in   1      0 = stop issuing new blocks (retire continues)
// - core_start    out  N      one-hot, 1-cycle start strobe to core k
// - core_block    out  128    counter block for the strobed core
// - core_done     in   N      1-cycle done strobe from core k
// - core_result   in   N*128  core k result on bits [k*128 +: 128]
// - ks_valid      out  1      keystream block available
// - ks_ready      in   1      consumer accepts keystream
// - ks_data       out  128    keystream block
// - busy          out  1      state != IDLE
// - inflight      out  $clog2(N+1)  number of slots in BUSY
// - ctr_wrap_err  out  1      sticky counter-wrap flag (macro only, else 0)
// BEHAVIOUR
// - Reset: FSM=IDLE, all slots FREE, ip=rp=0, ctr=0; every output 0.
// - FSM, IDLE -> RUN on load: ctr<=iv.
// - FSM, RUN + load: if inflight==0, reload in place (ctr<=iv, slots FREE, ip=rp=0, held results dropped); else latch iv and go to DRAIN.
// - FSM, DRAIN: no issue, ks_valid=0. Arriving done strobes are captured and discarded. A load re-latches iv.
// - FSM, DRAIN -> RUN when inflight==0: slots FREE, ip=rp=0, ctr<=latched iv.
// - Slot states: FREE -> BUSY (issued) -> DONE (result held) -> FREE (retired).
// - Issue: in RUN with enable=1 and slot[ip]==FREE -> core_start[ip]=1, core_block=ctr; next cycle ctr++, ip=(ip+1)%N.
// - Issue limits: at most one issue per cycle. core_start and core_block are decoded from registered state, no input-to-output path.
// - Load latency: load sampled at cycle t gives the first core_start at t+1 (core_block=iv).
// - Counter arithmetic: ctr[W-1:0] increments modulo 2^W; ctr[127:W] never changes within a session.
// - Capture: core_done[k] with slot k BUSY -> store result, slot DONE. core_done on a non-BUSY slot is ignored.
// - Simultaneous done strobes from several cores are all captured in the same cycle.
// - Retire: ks_valid = RUN && slot[rp]==DONE; ks_data = result[rp]. On ks_valid&&ks_ready -> slot FREE, rp++.
// - Order: output is always in issue order, even when cores finish out of order.
// - A slot freed in cycle t can be reissued at t+1 at the earliest.
// - Handshake: once ks_valid is asserted, ks_valid and ks_data stay stable until accepted, unless load or rst occurs.
// - Reset mid-operation: state cleared immediately. Late core_done strobes after reset hit FREE slots and are ignored.
// - Backpressure: with ks_ready=0, at most N blocks are issued beyond the last retired block, then issue stalls.
// CONFIGURATION
// - Macro: AES_CTR_WRAP_STOP_EN.
// - Defined: after issuing the block with ctr[W-1:0]=all-ones, set ctr_wrap_err (sticky) and issue nothing more.
//   Retire continues. ctr_wrap_err clears on load or rst.
// - Undefined: counter wraps silently to 0 and issue continues. ctr_wrap_err is tied to 0.
// TESTING (N=2, W=32, core model: done 14 cycles after start)
// - Basic run: iv=F0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF, ks_ready=1
//   -> core_block sequence ..FCFDFEFF, ..FCFDFF00, ..FCFDFF01; ks_data in the same order.
// - Out-of-order completion: core1 done 3 cycles before core0
//   -> first ks_data = core0 result, then core1 result; inflight goes 2 -> 1 -> 0.
// - Backpressure: ks_ready=0
//   -> exactly 2 core_start pulses, then none; ks_valid held stable; set ks_ready=1 -> issue resumes next cycle.
// - Reload while busy: load with iv=0..0 while inflight=2
//   -> DRAIN, ks_valid=0, old results never appear on ks_data; first new core_block=0.
// - Wrap: iv low word=FFFFFFFF
//   -> next core_block low word=00000000, upper 96 bits unchanged.
//   -> With macro: no second core_start; ctr_wrap_err=1 until load.
// - Async reset mid-run: all outputs 0 within the reset cycle; FSM in IDLE; no core_start until load.

Source files
------------

// File: rtl/aes256_ctr_core_scheduler.sv
// aes256_ctr_core_scheduler
// Issues consecutive AES-256 CTR counter blocks to NUM_AES_CORES block cores
// in round-robin order. Results are retired as keystream strictly in issue
// order. Each core slot doubles as a one-entry keystream buffer.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   load, iv            start a new session with counter block iv
//   enable              0 stops issuing new blocks (retire continues)
//   core_start          one-hot start strobe per core (registered)
//   core_block          counter block for the strobed core (registered)
//   core_done           per-core done strobe
//   core_result         core k result on bits [k*128 +: 128]
//   ks_valid/ks_ready   keystream handshake
//   ks_data             keystream block
//   busy                scheduler not idle
//   inflight            number of slots waiting on a core
//   ctr_wrap_err        sticky counter-wrap flag
//
// Optional feature macro: AES_CTR_WRAP_STOP_EN
//   defined   : issue stops after the block with an all-ones counter field,
//               ctr_wrap_err is set until the next load or reset
//   undefined : counter field wraps silently, ctr_wrap_err is tied to 0
module aes256_ctr_core_scheduler #(
    parameter int unsigned NUM_AES_CORES    = 2,
    parameter int unsigned IV_COUNTER_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load,
    input  logic [127:0]                         iv,
    input  logic                                 enable,
    output logic [NUM_AES_CORES-1:0]             core_start,
    output logic [127:0]                         core_block,
    input  logic [NUM_AES_CORES-1:0]             core_done,
    input  logic [NUM_AES_CORES*128-1:0]         core_result,
    output logic                                 ks_valid,
    input  logic                                 ks_ready,
    output logic [127:0]                         ks_data,
    output logic                                 busy,
    output logic [$clog2(NUM_AES_CORES+1)-1:0]   inflight,
    output logic                                 ctr_wrap_err
);
    localparam int unsigned N  = NUM_AES_CORES;
    localparam int unsigned W  = IV_COUNTER_WIDTH;
    localparam int unsigned BW = 128;
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
    typedef enum logic [1:0] {SL_FREE, SL_BUSY, SL_DONE} slot_t;

    state_t          state_q, state_d;
    slot_t           slot_q [N];
    slot_t           slot_d [N];
    logic [BW-1:0]   result_q [N];
    logic [N-1:0]    capture_c;
    logic [PW-1:0]   ip_q, ip_d, rp_q, rp_d, ip_v;
    logic [BW-1:0]   ctr_q, ctr_d, ctr_v;
    logic [BW-1:0]   iv_hold_q, iv_hold_d;
    logic [N-1:0]    start_q, start_d;
    logic [BW-1:0]   block_q, block_d;
    logic            retire_c, new_session_c, avail_c, issue_c, wrap_v;
    logic [CW-1:0]   inflight_c;

`ifdef AES_CTR_WRAP_STOP_EN
    logic wrap_q, wrap_d;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == N - 1) ? '0 : p + PW'(1);
    endfunction

    // Count slots still waiting on their core.
    always_comb begin
        inflight_c = '0;
        for (int k = 0; k < N; k++) begin
            if (slot_q[k] == SL_BUSY) inflight_c = inflight_c + CW'(1);
        end
    end

    assign ks_valid     = (state_q == S_RUN) && (slot_q[rp_q] == SL_DONE);
    assign ks_data      = ks_valid ? result_q[rp_q] : '0;
    assign busy         = (state_q != S_IDLE);
    assign inflight     = inflight_c;
    assign core_start   = start_q;
    assign core_block   = block_q;

    // Next-state: capture, retire, session control, then issue.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        ip_d          = ip_q;
        rp_d          = rp_q;
        ctr_d         = ctr_q;
        iv_hold_d     = iv_hold_q;
        start_d       = '0;
        block_d       = block_q;
        capture_c     = '0;
        new_session_c = 1'b0;
        ip_v          = ip_q;
        ctr_v         = ctr_q;
`ifdef AES_CTR_WRAP_STOP_EN
        wrap_v        = wrap_q;
`else
        wrap_v        = 1'b0;
`endif
        retire_c      = ks_valid && ks_ready;

        // Results arriving while draining are dropped by freeing the slot.
        for (int k = 0; k < N; k++) begin
            if (core_done[k] && (slot_q[k] == SL_BUSY)) begin
                if (state_q == S_RUN) begin
                    slot_d[k]    = SL_DONE;
                    capture_c[k] = 1'b1;
                end else begin
                    slot_d[k] = SL_FREE;
                end
            end
        end

        if (retire_c) begin
            slot_d[rp_q] = SL_FREE;
            rp_d         = ptr_inc(rp_q);
        end

        case (state_q)
            S_IDLE: begin
                if (load) new_session_c = 1'b1;
            end
            S_RUN: begin
                if (load) begin
                    if (inflight_c == '0) begin
                        new_session_c = 1'b1;
                    end else begin
                        state_d   = S_DRAIN;
                        iv_hold_d = iv;
                    end
                end
            end
            S_DRAIN: begin
                if (load) iv_hold_d = iv;
                if (inflight_c == '0) new_session_c = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (new_session_c) begin
            state_d = S_RUN;
            for (int k = 0; k < N; k++) slot_d[k] = SL_FREE;
            rp_d   = '0;
            ip_v   = '0;
            ctr_v  = load ? iv : iv_hold_q;
            wrap_v = 1'b0;
        end

        ip_d  = ip_v;
        ctr_d = ctr_v;
`ifdef AES_CTR_WRAP_STOP_EN
        wrap_d = wrap_v;
`endif

        // A slot being retired this cycle may be reissued immediately.
        avail_c = new_session_c || (slot_q[ip_q] == SL_FREE) ||
                  (retire_c && (rp_q == ip_q));
        issue_c = (state_d == S_RUN) && (new_session_c || !load) &&
                  enable && avail_c && !wrap_v;

        if (issue_c) begin
            start_d[ip_v]  = 1'b1;
            block_d        = ctr_v;
            slot_d[ip_v]   = SL_BUSY;
            ip_d           = ptr_inc(ip_v);
            ctr_d[W-1:0]   = ctr_v[W-1:0] + W'(1);
`ifdef AES_CTR_WRAP_STOP_EN
            if (&ctr_v[W-1:0]) wrap_d = 1'b1;
`endif
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ip_q      <= '0;
            rp_q      <= '0;
            ctr_q     <= '0;
            iv_hold_q <= '0;
            start_q   <= '0;
            block_q   <= '0;
            for (int k = 0; k < N; k++) begin
                slot_q[k]   <= SL_FREE;
                result_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ip_q      <= ip_d;
            rp_q      <= rp_d;
            ctr_q     <= ctr_d;
            iv_hold_q <= iv_hold_d;
            start_q   <= start_d;
            block_q   <= block_d;
            for (int k = 0; k < N; k++) begin
                slot_q[k] <= slot_d[k];
                if (capture_c[k]) result_q[k] <= core_result[k*BW +: BW];
            end
        end
    end

`ifdef AES_CTR_WRAP_STOP_EN
    // Sticky wrap flag, cleared by a new session.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wrap_q <= 1'b0;
        else     wrap_q <= wrap_d;
    end
    assign ctr_wrap_err = wrap_q;
`else
    assign ctr_wrap_err = 1'b0;
`endif

endmodule
